// File: rtl/exp_sched_pkg.sv
// exp_sched_pkg: shared widths and helpers for the exp scheduler.
//   DATA_W    operand/result width passed through unchanged
//   id_width  requester-index width, at least one bit
//   cnt_width credit counter width able to hold 0..depth
package exp_sched_pkg;

  localparam int unsigned DATA_W = 32;

  // Requester index width; never zero so a 1-bit id survives N_REQ=1 builds.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Credit counter must represent the full value "depth" itself.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/exp_rsp_fifo.sv
// exp_rsp_fifo: first-word fall-through response buffer for one requester.
//   CLK, RST_N  clock, asynchronous active-low reset
//   push        write push_data (ignored when full)
//   push_data   result word from the exp pipeline
//   pop         consume head (ignored when empty)
//   full/empty  occupancy flags from wrap-bit pointer compare
//   head        oldest entry, valid whenever !empty
module exp_rsp_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  // Equal index with differing wrap bit means the write side lapped the read side.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_push = push && !full;
    do_pop  = pop && !empty;
    head    = mem[rd_ptr[AW-1:0]];
  end

  // Pointer state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; empty masks stale contents.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/exp_sched.sv
// exp_sched: shares one exp pipeline between N_REQ requesters.
//   CLK, RST_N   clock, asynchronous active-low reset
//   req_valid    per-requester request valid
//   req_data     operand x, slice i for requester i
//   req_ready    grant this cycle (combinational, from registered credit state)
//   rsp_valid    per-requester response available
//   rsp_data     exp(x) result, slice i
//   rsp_ready    per-requester consumer ready
//   exp_data     registered operand to the exp pipeline
//   exp_result   exp pipeline output, aligned by the tag pipe
//   busy         any result in flight or buffered
module exp_sched
  import exp_sched_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned EXP_LAT    = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W*N_REQ-1:0] rsp_data,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       exp_data,
  input  logic [DATA_W-1:0]       exp_result,
  output logic                    busy
);

  localparam int unsigned ID_W  = id_width(N_REQ);
  localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);

  logic [CNT_W-1:0]  cnt [N_REQ];
  logic [ID_W-1:0]   rr_ptr;
  logic              ready_en;
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   rr_next;
  logic              found;
  logic [DATA_W-1:0] sel_data;
  logic [N_REQ-1:0]  pop;
  logic [N_REQ-1:0]  push;
  logic [N_REQ-1:0]  fifo_full;
  logic [N_REQ-1:0]  fifo_empty;
  logic              tag_vld [EXP_LAT+1];
  logic [ID_W-1:0]   tag_id  [EXP_LAT+1];

  // Eligibility uses only registered credit: a pop frees a slot next cycle.
  // ready_en keeps grants off until the first edge after reset release.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = ready_en && req_valid[i] && (cnt[i] < CNT_W'(FIFO_DEPTH));
    end
  end

  // Round-robin: search indices >= rr_ptr first, then wrap to those below it.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && eligible[i] && (ID_W'(i) >= rr_ptr)) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && eligible[i] && (ID_W'(i) < rr_ptr)) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
    rr_next = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Handshakes, FIFO routing and status.
  always_comb begin
    req_ready = grant;
    rsp_valid = ~fifo_empty;
    pop       = rsp_ready & ~fifo_empty;
    busy      = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      push[i] = tag_vld[EXP_LAT] && (tag_id[EXP_LAT] == ID_W'(i));
      busy    = busy | (cnt[i] != '0);
    end
  end

  // Issue register, tag pipe, round-robin pointer and credit counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ready_en <= 1'b0;
      rr_ptr   <= '0;
      exp_data <= '0;
      for (int s = 0; s <= EXP_LAT; s++) begin
        tag_vld[s] <= 1'b0;
        tag_id[s]  <= '0;
      end
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      ready_en   <= 1'b1;
      tag_vld[0] <= found;
      tag_id[0]  <= grant_idx;
      if (found) begin
        rr_ptr   <= rr_next;
        exp_data <= sel_data;
      end
      for (int s = 1; s <= EXP_LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
      for (int i = 0; i < N_REQ; i++) begin
        case ({grant[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
          2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // One response buffer per requester.
  for (genvar g = 0; g < N_REQ; g++) begin : g_fifo
    exp_rsp_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .push      (push[g]),
      .push_data (exp_result),
      .pop       (pop[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g]),
      .head      (rsp_data[g*DATA_W +: DATA_W])
    );

    // Credit accounting makes this unreachable; firing means a counter bug.
    a_no_overflow : assert property (@(posedge CLK) disable iff (!RST_N)
                                     !(push[g] && fifo_full[g]));
  end

endmodule

// File: tb/tb_exp_sched.sv
// tb_exp_sched: scoreboard bench for exp_sched with a behavioural exp stand-in.
module tb_exp_sched;

  localparam int unsigned N_REQ      = 2;
  localparam int unsigned EXP_LAT    = 3;
  localparam int unsigned FIFO_DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [63:0] req_data = '0;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_ready = '0;
  logic [31:0] exp_data;
  logic [31:0] exp_result;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;
  logic [31:0] sb0[$];
  logic [31:0] sb1[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  exp_sched #(
    .N_REQ      (N_REQ),
    .EXP_LAT    (EXP_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready),
    .exp_data   (exp_data),
    .exp_result (exp_result),
    .busy       (busy)
  );

  // Truncated Taylor exp in 5.10 fixed point: 1 + x + x^2/2 + x^3/6.
  function automatic logic [31:0] exp_f(input logic [31:0] x);
    logic signed [63:0] xs, x2, x3, r;
    xs = {{32{x[31]}}, x};
    x2 = (xs * xs) >>> 10;
    x3 = (x2 * xs) >>> 10;
    r  = 64'sd1024 + xs + x2 / 2 + x3 / 6;
    return r[31:0];
  endfunction

  // exp stand-in: samples exp_data each edge, result valid EXP_LAT edges later.
  logic [31:0] xpipe [EXP_LAT];
  always_ff @(posedge CLK) begin
    xpipe[0] <= exp_f(exp_data);
    for (int s = 1; s < EXP_LAT; s++) xpipe[s] <= xpipe[s-1];
  end
  assign exp_result = xpipe[EXP_LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_vec++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp_v);
    end
  endtask

  // Record this cycle's handshakes into the scoreboard, then advance to the next negedge.
  task automatic step();
    if (req_valid[0] && req_ready[0]) sb0.push_back(exp_f(req_data[31:0]));
    if (req_valid[1] && req_ready[1]) sb1.push_back(exp_f(req_data[63:32]));
    if (rsp_valid[0] && rsp_ready[0]) begin
      check("rsp0_pending", 32'(sb0.size() != 0), 32'd1);
      if (sb0.size() != 0) check("rsp0_data", rsp_data[31:0], sb0.pop_front());
    end
    if (rsp_valid[1] && rsp_ready[1]) begin
      check("rsp1_pending", 32'(sb1.size() != 0), 32'd1);
      if (sb1.size() != 0) check("rsp1_data", rsp_data[63:32], sb1.pop_front());
    end
    @(negedge CLK);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      #1;
      step();
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = '0;
    RST_N = 1'b0;
    sb0.delete();
    sb1.delete();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          acc_edge;
    int          a0;
    int          a1;
    int          nseen;
    int          edges [3];
    logic        found;
    logic        g1;
    logic [31:0] xs [3];

    // Reset state, with requests pending to show grants are held off.
    #2;
    req_valid = 2'b11;
    RST_N = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_exp_data", exp_data, 32'd0);
    @(negedge CLK);
    do_reset();

    // Single request, latency and busy.
    req_valid = 2'b01;
    req_data  = '0;
    rsp_ready = 2'b11;
    #1;
    check("t1_ready", 32'(req_ready), 32'd1);
    acc_edge = edge_cnt + 1;
    step();
    req_valid = '0;
    #1;
    check("t1_busy", 32'(busy), 32'd1);
    step();
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      #1;
      if (rsp_valid[0]) begin
        found = 1'b1;
        check("t1_lat", 32'(edge_cnt - acc_edge), 32'd4);
        check("t1_data", rsp_data[31:0], 32'h400);
      end
      step();
    end
    check("t1_seen", 32'(found), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);

    // Both requesters continuous: strict alternation from requester 0.
    do_reset();
    rsp_ready = 2'b11;
    g1 = 1'b0;
    for (int n = 0; n < 10; n++) begin
      req_valid = 2'b11;
      req_data  = {32'($urandom_range(0, 2047)), 32'($urandom_range(0, 2047))};
      #1;
      check("t2_grant", 32'(req_ready), g1 ? 32'd2 : 32'd1);
      step();
      g1 = ~g1;
    end
    req_valid = '0;
    tick(20);
    check("t2_sb0_left", 32'(sb0.size()), 32'd0);
    check("t2_sb1_left", 32'(sb1.size()), 32'd0);

    // Back-to-back on requester 1 only.
    do_reset();
    rsp_ready = 2'b11;
    xs[0] = 32'h400;
    xs[1] = 32'h200;
    xs[2] = 32'h0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 2'b10;
      req_data  = {xs[k], 32'h0};
      #1;
      check("t3_acc", 32'(req_ready), 32'd2);
      step();
    end
    req_valid = '0;
    nseen = 0;
    for (int n = 0; n < 12; n++) begin
      #1;
      if (rsp_valid[1] && nseen < 3) begin
        edges[nseen] = edge_cnt;
        nseen++;
      end
      step();
    end
    check("t3_count", 32'(nseen), 32'd3);
    check("t3_gap01", 32'(edges[1] - edges[0]), 32'd1);
    check("t3_gap12", 32'(edges[2] - edges[1]), 32'd1);

    // Stalled consumer 0: credit caps accepts, requester 1 keeps going.
    do_reset();
    rsp_ready = 2'b10;
    a0 = 0;
    a1 = 0;
    for (int n = 0; n < 24; n++) begin
      req_valid = 2'b11;
      req_data  = {32'($urandom_range(0, 2047)), 32'($urandom_range(0, 2047))};
      #1;
      if (req_ready[0]) a0++;
      if (n >= 12 && req_ready[1]) a1++;
      step();
    end
    check("t4_acc0", 32'(a0), 32'd4);
    check("t4_req1_served", 32'(a1 >= 6), 32'd1);
    rsp_ready = 2'b11;
    #1;
    check("t4_pulse_rdy", 32'(req_ready[0]), 32'd0);
    step();
    rsp_ready = 2'b10;
    #1;
    check("t4_after_rdy", 32'(req_ready[0]), 32'd1);
    step();
    req_valid = '0;
    rsp_ready = 2'b11;
    tick(30);
    check("t4_sb0_left", 32'(sb0.size()), 32'd0);
    check("t4_sb1_left", 32'(sb1.size()), 32'd0);

    // Asynchronous reset with two requests in flight.
    do_reset();
    rsp_ready = 2'b11;
    req_valid = 2'b01;
    req_data  = {32'h100, 32'h80};
    tick(1);
    req_valid = 2'b10;
    tick(1);
    req_valid = '0;
    check("t5_busy_pre", 32'(busy), 32'd1);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check("t5_req_ready", 32'(req_ready), 32'd0);
    check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    sb0.delete();
    sb1.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    for (int n = 0; n < 10; n++) begin
      #1;
      check("t5_quiet", 32'(rsp_valid), 32'd0);
      step();
    end

    // Simultaneous push and pop on requester 0 at cnt=2.
    do_reset();
    rsp_ready = 2'b00;
    for (int k = 0; k < 2; k++) begin
      req_valid = 2'b01;
      req_data  = {32'h0, 32'($urandom_range(0, 2047))};
      tick(1);
    end
    req_valid = '0;
    tick(8);
    check("t6_cnt_pre", 32'(dut.cnt[0]), 32'd2);
    req_valid = 2'b01;
    req_data  = {32'h0, 32'($urandom_range(0, 2047))};
    rsp_ready = 2'b01;
    #1;
    check("t6_both", 32'({req_ready[0], rsp_valid[0]}), 32'd3);
    step();
    req_valid = '0;
    rsp_ready = 2'b00;
    #1;
    check("t6_cnt", 32'(dut.cnt[0]), 32'd2);
    check("t6_occ", 32'(rsp_valid[0]), 32'd1);
    step();
    rsp_ready = 2'b01;
    tick(12);
    check("t6_sb0_left", 32'(sb0.size()), 32'd0);
    check("t6_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
